// File: rtl/rng_seed_loader.sv
// Seed loader: streams bytes into a byte-addressed state register, either
// overwriting each byte or XOR-mixing it with the current contents.
module rng_seed_loader #(
    parameter int NUM_BYTES  = 32,
    parameter int TOTAL_BITS = 8 * NUM_BYTES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic                  abort,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    input  logic [TOTAL_BITS-1:0] q_bytes,
    output logic [NUM_BYTES-1:0]  w_en_bytes,
    output logic [TOTAL_BITS-1:0] w_data_bytes,
    output logic                  busy,
    output logic                  done
);

    localparam int IDX_W = (NUM_BYTES > 2) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     idx;
    logic                 mode_q;
    logic                 xfer;
    logic [7:0]           q_sel;
    logic [7:0]           wr_byte;
    logic [NUM_BYTES-1:0] w_en_nxt;
    logic [TOTAL_BITS-1:0] w_data_nxt;

    assign s_ready = (state == LOAD) && !abort;
    assign xfer    = s_valid && s_ready;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (start) state_nxt = LOAD;
            LOAD: begin
                if (abort)                          state_nxt = IDLE;
                else if (xfer && idx == LAST_IDX)   state_nxt = FLUSH;
            end
            FLUSH: state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Byte of the current state under the write pointer, for XOR mixing.
    always_comb begin
        q_sel = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (idx == IDX_W'(i)) q_sel = q_bytes[8*i +: 8];
        end
    end

    assign wr_byte = mode_q ? (s_data ^ q_sel) : s_data;

    always_comb begin
        w_en_nxt   = '0;
        w_data_nxt = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (xfer && idx == IDX_W'(i)) begin
                w_en_nxt[i]          = 1'b1;
                w_data_nxt[8*i +: 8] = wr_byte;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            mode_q       <= 1'b0;
            w_en_bytes   <= '0;
            w_data_bytes <= '0;
        end else begin
            state        <= state_nxt;
            w_en_bytes   <= w_en_nxt;
            w_data_bytes <= w_data_nxt;
            if (state == IDLE && start) begin
                idx    <= '0;
                mode_q <= mode;
            end else if (xfer && idx != LAST_IDX) begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rng_seed_loader.sv
// Directed bench for rng_seed_loader with NUM_BYTES=4: per-cycle vector table
// plus a hand-written asynchronous-reset sequence.
module tb_rng_seed_loader;

    localparam int NB = 4;
    localparam int TB = 8 * NB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic          abort = 1'b0;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = 8'h00;
    logic [TB-1:0] q_bytes = '0;
    logic          s_ready;
    logic [NB-1:0] w_en_bytes;
    logic [TB-1:0] w_data_bytes;
    logic          busy;
    logic          done;

    rng_seed_loader #(.NUM_BYTES(NB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .mode         (mode),
        .abort        (abort),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .q_bytes      (q_bytes),
        .w_en_bytes   (w_en_bytes),
        .w_data_bytes (w_data_bytes),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        start;
        logic        mode;
        logic        abort;
        logic        s_valid;
        logic [7:0]  s_data;
        logic [31:0] q;
        logic        rdy;
        logic [3:0]  wen;
        logic [31:0] wdata;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic md, input logic ab, input logic sv,
                       input logic [7:0] sd, input logic [31:0] q, input logic rdy,
                       input logic [3:0] wen, input logic [31:0] wd,
                       input logic bsy, input logic dn);
        vec_t v;
        v.start = st; v.mode = md; v.abort = ab; v.s_valid = sv; v.s_data = sd; v.q = q;
        v.rdy = rdy; v.wen = wen; v.wdata = wd; v.busy = bsy; v.done = dn;
        vecs.push_back(v);
    endtask

    task automatic check_all(input string tag, input logic rdy, input logic [3:0] wen,
                             input logic [31:0] wd, input logic bsy, input logic dn);
        check({tag, " s_ready"}, 32'(s_ready), 32'(rdy));
        check({tag, " w_en"},    32'(w_en_bytes), 32'(wen));
        check({tag, " w_data"},  w_data_bytes, wd);
        check({tag, " busy"},    32'(busy), 32'(bsy));
        check({tag, " done"},    32'(done), 32'(dn));
    endtask

    initial begin
        int          n_strobe;
        logic [31:0] acc;
        int          cyc_done;

        // Columns: start mode abort s_valid s_data q | s_ready w_en w_data busy done
        // Overwrite load, back-to-back bytes
        add(1,0,0,0,8'h00,32'h0, 0,4'h0,32'h00000000,0,0);
        add(0,0,0,1,8'h11,32'h0, 1,4'h0,32'h00000000,1,0);
        add(0,0,0,1,8'h22,32'h0, 1,4'h1,32'h00000011,1,0);
        add(0,0,0,1,8'h33,32'h0, 1,4'h2,32'h00002200,1,0);
        add(0,0,0,1,8'h44,32'h0, 1,4'h4,32'h00330000,1,0);
        add(0,0,0,0,8'h00,32'h0, 0,4'h8,32'h44000000,1,0);
        add(0,0,0,0,8'h00,32'h0, 0,4'h0,32'h00000000,1,1);
        add(0,0,0,0,8'h00,32'h0, 0,4'h0,32'h00000000,0,0);
        // XOR mix; mode input dropped after start to show it is latched
        add(1,1,0,0,8'h00,32'hF0F0F0F0, 0,4'h0,32'h00000000,0,0);
        add(0,0,0,1,8'h0F,32'hF0F0F0F0, 1,4'h0,32'h00000000,1,0);
        add(0,0,0,1,8'hFF,32'hF0F0F0F0, 1,4'h1,32'h000000FF,1,0);
        add(0,0,0,1,8'h00,32'hF0F0F0F0, 1,4'h2,32'h00000F00,1,0);
        add(0,0,0,1,8'hAA,32'hF0F0F0F0, 1,4'h4,32'h00F00000,1,0);
        add(0,0,0,0,8'h00,32'hF0F0F0F0, 0,4'h8,32'h5A000000,1,0);
        add(0,0,0,0,8'h00,32'hF0F0F0F0, 0,4'h0,32'h00000000,1,1);
        add(0,0,0,0,8'h00,32'h0,        0,4'h0,32'h00000000,0,0);
        // Gaps in s_valid, start during LOAD, abort in FLUSH, start in DONE, abort in IDLE
        add(1,0,0,0,8'h00,32'h0, 0,4'h0,32'h00000000,0,0);
        add(0,0,0,1,8'hA1,32'h0, 1,4'h0,32'h00000000,1,0);
        add(0,0,0,0,8'h00,32'h0, 1,4'h1,32'h000000A1,1,0);
        add(1,0,0,0,8'h00,32'h0, 1,4'h0,32'h00000000,1,0);
        add(0,0,0,1,8'hB2,32'h0, 1,4'h0,32'h00000000,1,0);
        add(0,0,0,0,8'h00,32'h0, 1,4'h2,32'h0000B200,1,0);
        add(0,0,0,0,8'h00,32'h0, 1,4'h0,32'h00000000,1,0);
        add(0,0,0,1,8'hC3,32'h0, 1,4'h0,32'h00000000,1,0);
        add(0,0,0,1,8'hD4,32'h0, 1,4'h4,32'h00C30000,1,0);
        add(0,0,1,0,8'h00,32'h0, 0,4'h8,32'hD4000000,1,0);
        add(1,0,0,0,8'h00,32'h0, 0,4'h0,32'h00000000,1,1);
        add(0,0,1,0,8'h00,32'h0, 0,4'h0,32'h00000000,0,0);
        // Abort after two transfers with s_valid held high
        add(1,0,0,0,8'h00,32'h0, 0,4'h0,32'h00000000,0,0);
        add(0,0,0,1,8'h11,32'h0, 1,4'h0,32'h00000000,1,0);
        add(0,0,0,1,8'h22,32'h0, 1,4'h1,32'h00000011,1,0);
        add(0,0,1,1,8'h33,32'h0, 0,4'h2,32'h00002200,1,0);
        add(0,0,0,1,8'h44,32'h0, 0,4'h0,32'h00000000,0,0);
        add(0,0,0,0,8'h00,32'h0, 0,4'h0,32'h00000000,0,0);
        // start held high: back-to-back operations with one IDLE gap
        add(1,0,0,0,8'h00,32'h0, 0,4'h0,32'h00000000,0,0);
        add(1,0,0,1,8'h01,32'h0, 1,4'h0,32'h00000000,1,0);
        add(1,0,0,1,8'h02,32'h0, 1,4'h1,32'h00000001,1,0);
        add(1,0,0,1,8'h03,32'h0, 1,4'h2,32'h00000200,1,0);
        add(1,0,0,1,8'h04,32'h0, 1,4'h4,32'h00030000,1,0);
        add(1,0,0,0,8'h00,32'h0, 0,4'h8,32'h04000000,1,0);
        add(1,0,0,0,8'h00,32'h0, 0,4'h0,32'h00000000,1,1);
        add(1,0,0,0,8'h00,32'h0, 0,4'h0,32'h00000000,0,0);
        add(1,0,0,1,8'h05,32'h0, 1,4'h0,32'h00000000,1,0);
        add(0,0,1,0,8'h00,32'h0, 0,4'h1,32'h00000005,1,0);
        add(0,0,0,0,8'h00,32'h0, 0,4'h0,32'h00000000,0,0);

        #3;
        check_all("reset", 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
        #9 rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            start   = vecs[i].start;
            mode    = vecs[i].mode;
            abort   = vecs[i].abort;
            s_valid = vecs[i].s_valid;
            s_data  = vecs[i].s_data;
            q_bytes = vecs[i].q;
            @(negedge clk);
            check_all($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].wen, vecs[i].wdata,
                      vecs[i].busy, vecs[i].done);
        end

        // Asynchronous reset between edges while a strobe is pending
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b0; s_valid = 1'b0; q_bytes = '0;
        @(posedge clk); #1;
        start = 1'b0; s_valid = 1'b1; s_data = 8'hAA;
        @(posedge clk); #1;
        s_data = 8'hBB;
        #2 rst_n = 1'b0;
        #1 check_all("async_rst", 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b1; start = 1'b1; s_valid = 1'b0;

        n_strobe = 0;
        acc      = '0;
        cyc_done = -1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(posedge clk); #1;
            start   = 1'b0;
            s_valid = (cyc < 4);
            s_data  = 8'(cyc + 1);
            @(negedge clk);
            if (cyc == 0) check("post_rst s_ready", 32'(s_ready), 32'd1);
            if (w_en_bytes != '0) begin
                n_strobe++;
                acc = acc | w_data_bytes;
            end
            if (done && cyc_done < 0) cyc_done = cyc;
        end
        check("post_rst strobes", 32'(n_strobe), 32'd4);
        check("post_rst data", acc, 32'h04030201);
        check("post_rst done cycle", 32'(cyc_done), 32'd5);
        check("post_rst idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
